imem_loadable: RTL and testbench
================================

Name: imem_loadable

Overview:
- Parametrised synchronous instruction memory for the EC413 pipelined processor. Replaces hardcoded per-program case tables.
- The program image is streamed in at run time through a sequential loader port.
- The IF stage then fetches instructions with a one-cycle-latency request/valid handshake.
- Supports a pipeline stall hold, flush, word or byte PC addressing, and NOP substitution beyond program length.

Parameters:
- DATA_W, 32, instruction width in bits.
- DEPTH, 64, number of instruction words stored (power of two).
- PC_W, 32, width of fetch address.
- BYTE_ADDR, 0, 0 = PC counts words (PC+1 per instruction); 1 = PC counts bytes (index = PC>>2).
- NOP_WORD, 0, value returned for empty, out-of-range or flushed fetches.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse: clear program, enter LOADING, load pointer := 0.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  instruction word to append.
- load_done  in  1  pulse: end of image, enter READY.
- load_ready  out  1  high in LOADING while the pointer is below DEPTH.
- prog_len  out  $clog2(DEPTH)+1  number of words loaded.
- fetch_req  in  1  IF stage requests the instruction at fetch_pc.
- fetch_pc  in  PC_W  fetch address.
- stall  in  1  hold the fetch output register.
- flush  in  1  replace the pending fetch output with NOP_WORD.
- fetch_valid  out  1  instr is valid.
- instr  out  DATA_W  fetched instruction.
- fetch_err  out  1  misaligned (BYTE_ADDR=1) or out-of-range fetch; qualified by fetch_valid.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, rst_n low): state=EMPTY, load pointer=0, prog_len=0, fetch_valid=0, instr=NOP_WORD, fetch_err=0, load_ready=0. Memory contents are not reset.
- FSM states: EMPTY(0), LOADING(1), READY(2).
  - EMPTY: load_start -> LOADING.
  - LOADING: load_done -> READY.
  - READY: load_start -> LOADING, prog_len:=0.
  - load_start has priority over load_done in the same cycle.
- Loading:
  - In LOADING, load_valid && load_ready writes mem[ptr]:=load_data, then ptr++ and prog_len++.
  - At ptr==DEPTH, load_ready=0 and further words are dropped without error.
  - A load_valid word coincident with load_done is written before the transition.
- Fetch index:
  - idx = fetch_pc when BYTE_ADDR=0; otherwise fetch_pc>>2.
  - misaligned = BYTE_ADDR && fetch_pc[1:0]!=0.
  - in_range = idx < prog_len.
- Fetch (registered, latency 1):
  - When stall=0, the cycle after fetch_req: fetch_valid=1.
  - instr = mem[idx] if state==READY && in_range && !misaligned; otherwise NOP_WORD.
  - fetch_err=1 iff (misaligned || !in_range) && state==READY.
  - fetch_req=0 with stall=0 gives fetch_valid=0 next cycle.
- Fetch outside READY: fetch_valid=1, instr=NOP_WORD, fetch_err=0, so the pipeline sees NOPs while loading.
- Stall: the output register (fetch_valid, instr, fetch_err) holds; new fetch_req values are ignored.
- Flush: the next edge sets instr=NOP_WORD and fetch_err=0. fetch_valid takes its normal value. Flush overrides stall.
- Read/write collision: a fetch of the index being written in the same cycle returns the old contents, i.e. NOP_WORD because idx>=prog_len still holds.
- Index width: idx is compared at full PC_W width, so large PCs never alias into the array.

Decomposition:
- Shared package imem_pkg holds:
  - state encodings ST_EMPTY/ST_LOADING/ST_READY;
  - the NOP_WORD default;
  - a function computing word index and misalignment from a PC.
- One sub-module, imem_ram: single write port, single synchronous read port, DEPTH x DATA_W, read-old-on-collision.
- Control FSM, load pointer and fetch output logic stay in the top module.

Test Plan:
- Load and fetch: reset, load_start, stream 3 words (0xE4200A00, 0xE4400014, 0x48221000), load_done. Fetch pc 0,1,2,3 -> instr = those three words then 0; fetch_err=1 only on pc 3; prog_len=3.
- Byte mode: BYTE_ADDR=1, same image. Fetch pc 4 -> 0xE4400014, err=0. Fetch pc 6 -> NOP, err=1.
- Stall and flush: fetch pc0, then stall=1 for 3 cycles while fetch_pc=1 -> instr holds the pc0 word. Assert flush during the stall -> instr=0 next edge.
- Overflow: DEPTH=4, stream 6 words -> load_ready drops after 4 writes, prog_len=4, words 5 and 6 absent.
- Reload and reset: in READY, load_start -> fetches return NOP with err=0, prog_len=0. Drop rst_n mid-load -> state EMPTY, fetch_valid=0 immediately, with no clock edge needed.
- Simultaneous load_start and load_done -> LOADING. load_valid with load_done -> final word written and visible in READY.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared state encodings, NOP default and PC decoding for the loadable instruction memory.
package imem_pkg;
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_LOADING = 2'd1, ST_READY = 2'd2} state_t;
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
   localparam int PC_MAX_W = 64;
   typedef struct packed {
      logic [PC_MAX_W-1:0] idx;
      logic misaligned;
   } pc_dec_t;
   function automatic pc_dec_t decode_pc(input logic [PC_MAX_W-1:0] pc, input logic byte_addr);
      pc_dec_t d;
      d.idx = byte_addr ? pc >> 2 : pc;
      d.misaligned = byte_addr && pc[1:0] != 2'b00;
      return d;
   endfunction
endpackage

// File: rtl/imem_loadable_if.sv
// imem_loadable_if: loader stream and IF-stage fetch handshake of the instruction memory.
interface imem_loadable_if #(parameter int DATA_W = 32, parameter int DEPTH = 64, parameter int PC_W = 32);
   logic load_start, load_valid, load_done, load_ready;
   logic [DATA_W-1:0] load_data;
   logic [$clog2(DEPTH):0] prog_len;
   logic fetch_req, stall, flush, fetch_valid, fetch_err;
   logic [PC_W-1:0] fetch_pc;
   logic [DATA_W-1:0] instr;
   logic [1:0] state_o;
   modport master (output load_start, load_valid, load_data, load_done, fetch_req, fetch_pc, stall, flush,
                   input load_ready, prog_len, fetch_valid, instr, fetch_err, state_o);
   modport slave (input load_start, load_valid, load_data, load_done, fetch_req, fetch_pc, stall, flush,
                  output load_ready, prog_len, fetch_valid, instr, fetch_err, state_o);
endinterface

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x DATA_W array, one write port and one synchronous read port returning old data on collision.
module imem_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH = 64,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory with a latency-1 fetch port,
// stall hold, flush and NOP substitution outside the loaded program.
module imem_loadable import imem_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int DEPTH = 64,
   parameter int PC_W = 32,
   parameter bit BYTE_ADDR = 1'b0,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
   input logic clk,
   input logic rst_n,
   imem_loadable_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   state_t state;
   logic [AW:0] ptr;
   pc_dec_t dec;
   logic in_range, hit, load_ready, we, sel, valid, err;
   logic [DATA_W-1:0] rdata;
   assign dec = decode_pc(PC_MAX_W'(bus.fetch_pc), BYTE_ADDR);
   // Full-width compare so large PCs never alias onto low array entries.
   assign in_range = dec.idx < PC_MAX_W'(ptr);
   assign hit = state == ST_READY && in_range && !dec.misaligned;
   assign load_ready = state == ST_LOADING && ptr < (AW+1)'(DEPTH);
   assign we = !bus.load_start && bus.load_valid && load_ready;
   imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (ptr[AW-1:0]),
      .wdata (bus.load_data),
      .re    (!bus.stall),
      .raddr (dec.idx[AW-1:0]),
      .rdata (rdata)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_EMPTY;
         ptr <= '0;
      end else if (bus.load_start) begin
         state <= ST_LOADING;
         ptr <= '0;
      end else if (state == ST_LOADING) begin
         if (we) ptr <= ptr + 1'b1;
         if (bus.load_done) state <= ST_READY;
      end
   // sel marks that the held RAM word is a real instruction; otherwise NOP_WORD is shown.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= 1'b0;
         sel <= 1'b0;
         err <= 1'b0;
      end else begin
         if (!bus.stall) valid <= bus.fetch_req;
         if (bus.flush) begin
            sel <= 1'b0;
            err <= 1'b0;
         end else if (!bus.stall) begin
            sel <= bus.fetch_req && hit;
            err <= bus.fetch_req && state == ST_READY && !hit;
         end
      end
   assign bus.load_ready = load_ready;
   assign bus.prog_len = ptr;
   assign bus.fetch_valid = valid;
   assign bus.instr = sel ? rdata : NOP_WORD;
   assign bus.fetch_err = err;
   assign bus.state_o = state;
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: three configurations (word/64, byte/64, word/4) driven by one stimulus stream
// and compared against an array-based model of the loader and fetch rules.
module tb_imem_loadable;
   localparam int DEP[3] = '{64, 64, 4};
   localparam bit BYT[3] = '{1'b0, 1'b1, 1'b0};
   logic clk = 1'b0, rst_n = 1'b1;
   logic load_start = 0, load_valid = 0, load_done = 0, fetch_req = 0, stall = 0, flush = 0;
   logic [31:0] load_data = '0, fetch_pc = '0;
   int n_chk = 0, n_err = 0;
   always #5 clk = ~clk;

   imem_loadable_if #(.DEPTH(64)) if0 ();
   imem_loadable_if #(.DEPTH(64)) if1 ();
   imem_loadable_if #(.DEPTH(4)) if2 ();
   imem_loadable #(.BYTE_ADDR(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   imem_loadable #(.BYTE_ADDR(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   imem_loadable #(.DEPTH(4), .BYTE_ADDR(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   assign {if0.load_start, if1.load_start, if2.load_start} = {3{load_start}};
   assign {if0.load_valid, if1.load_valid, if2.load_valid} = {3{load_valid}};
   assign {if0.load_done, if1.load_done, if2.load_done} = {3{load_done}};
   assign {if0.fetch_req, if1.fetch_req, if2.fetch_req} = {3{fetch_req}};
   assign {if0.stall, if1.stall, if2.stall} = {3{stall}};
   assign {if0.flush, if1.flush, if2.flush} = {3{flush}};
   assign {if0.load_data, if1.load_data, if2.load_data} = {3{load_data}};
   assign {if0.fetch_pc, if1.fetch_pc, if2.fetch_pc} = {3{fetch_pc}};

   logic o_v[3], o_e[3], o_r[3];
   logic [31:0] o_i[3];
   logic [6:0] o_l[3];
   logic [1:0] o_s[3];
   assign o_v = '{if0.fetch_valid, if1.fetch_valid, if2.fetch_valid};
   assign o_e = '{if0.fetch_err, if1.fetch_err, if2.fetch_err};
   assign o_r = '{if0.load_ready, if1.load_ready, if2.load_ready};
   assign o_i = '{if0.instr, if1.instr, if2.instr};
   assign o_l = '{if0.prog_len, if1.prog_len, 7'(if2.prog_len)};
   assign o_s = '{if0.state_o, if1.state_o, if2.state_o};

   // Model: state 0/1/2, loaded program as an array plus length, and the expected output register.
   int m_st[3], m_len[3];
   logic [31:0] m_prog[3][64];
   logic e_v[3], e_e[3];
   logic [31:0] e_i[3];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("state%0d", k), 64'(o_s[k]), 64'(m_st[k]));
         chk($sformatf("prog_len%0d", k), 64'(o_l[k]), 64'(m_len[k]));
         chk($sformatf("load_ready%0d", k), 64'(o_r[k]), 64'(m_st[k] == 1 && m_len[k] < DEP[k]));
         chk($sformatf("fetch_valid%0d", k), 64'(o_v[k]), 64'(e_v[k]));
         if (e_v[k]) begin
            chk($sformatf("instr%0d", k), 64'(o_i[k]), 64'(e_i[k]));
            chk($sformatf("fetch_err%0d", k), 64'(o_e[k]), 64'(e_e[k]));
         end
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         longint unsigned idx = BYT[k] ? longint'(fetch_pc) / 4 : longint'(fetch_pc);
         bit mis = BYT[k] && (fetch_pc % 4) != 0;
         bit ok = m_st[k] == 2 && idx < longint'(m_len[k]) && !mis;
         if (!stall) e_v[k] = fetch_req;
         if (flush) begin
            e_i[k] = 32'h0;
            e_e[k] = 1'b0;
         end else if (!stall) begin
            e_i[k] = (fetch_req && ok) ? m_prog[k][int'(idx)] : 32'h0;
            e_e[k] = fetch_req && m_st[k] == 2 && !ok;
         end
         if (load_start) begin
            m_st[k] = 1;
            m_len[k] = 0;
         end else if (m_st[k] == 1) begin
            if (load_valid && m_len[k] < DEP[k]) begin
               m_prog[k][m_len[k]] = load_data;
               m_len[k]++;
            end
            if (load_done) m_st[k] = 2;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0;
         m_len[k] = 0;
         e_v[k] = 1'b0;
         e_i[k] = 32'h0;
         e_e[k] = 1'b0;
      end
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] pc);
      fetch_req = 1'b1;
      fetch_pc = pc;
      cycle();
   endtask

   task automatic load_image(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
      logic [31:0] img[3];
      img = '{w0, w1, w2};
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      load_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         load_data = img[i];
         cycle();
      end
      load_valid = 1'b0;
      load_done = 1'b1;
      cycle();
      load_done = 1'b0;
   endtask

   initial begin
      async_reset();
      chk("reset_instr", 64'(if0.instr), 64'h0);
      load_image(32'hE4200A00, 32'hE4400014, 32'h48221000);
      chk("plen3", 64'(if0.prog_len), 64'd3);
      for (int p = 0; p < 4; p++) fetch(32'(p));
      chk("pc3_err", 64'(if0.fetch_err), 64'd1);
      fetch(32'd4);
      chk("byte_pc4", 64'(if1.instr), 64'hE4400014);
      chk("byte_pc4_err", 64'(if1.fetch_err), 64'd0);
      fetch(32'd6);
      chk("byte_pc6_err", 64'(if1.fetch_err), 64'd1);
      fetch(32'hFFFF_FFF1);
      fetch(32'd0);
      stall = 1'b1;
      fetch_pc = 32'd1;
      for (int i = 0; i < 3; i++) cycle();
      chk("stall_hold", 64'(if0.instr), 64'hE4200A00);
      flush = 1'b1;
      cycle();
      chk("flush_nop", 64'(if0.instr), 64'h0);
      flush = 1'b0;
      stall = 1'b0;
      fetch(32'd2);
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      load_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         load_data = 32'h100 + 32'(i);
         cycle();
      end
      chk("ovf_ready", 64'(if2.load_ready), 64'd0);
      load_valid = 1'b0;
      load_done = 1'b1;
      cycle();
      load_done = 1'b0;
      chk("ovf_len", 64'(if2.prog_len), 64'd4);
      for (int p = 3; p < 7; p++) fetch(32'(p));
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      fetch(32'd0);
      chk("reload_nop", 64'(if0.instr), 64'h0);
      load_valid = 1'b1;
      load_data = 32'hABCD;
      cycle();
      load_valid = 1'b0;
      async_reset();
      load_start = 1'b1;
      load_done = 1'b1;
      cycle();
      load_start = 1'b0;
      chk("start_prio", 64'(if0.state_o), 64'd1);
      load_valid = 1'b1;
      load_data = 32'hCAFE_F00D;
      cycle();
      load_valid = 1'b0;
      load_done = 1'b0;
      fetch(32'd0);
      chk("last_word", 64'(if0.instr), 64'hCAFE_F00D);
      for (int n = 0; n < 3000; n++) begin
         int r = $urandom_range(0, 9);
         load_start = $urandom_range(0, 59) == 0;
         load_valid = $urandom_range(0, 1) == 1;
         load_done = $urandom_range(0, 19) == 0;
         load_data = $urandom;
         fetch_req = $urandom_range(0, 3) != 0;
         stall = $urandom_range(0, 4) == 0;
         flush = $urandom_range(0, 9) == 0;
         fetch_pc = r < 5 ? 32'($urandom_range(0, 70)) : r < 8 ? 32'(4 * $urandom_range(0, 70)) :
                    r == 8 ? 32'(m_len[0]) : $urandom;
         if ($urandom_range(0, 499) == 0) async_reset();
         else cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
